multi_spi_loader: RTL
=====================

MULTI_SPI_LOADER -- requirements
Module: multi_spi_loader

Interface
REQ-001 SHALL have parameter LANES, default 4, the nibble-lane count (bits accepted per beat).
REQ-002 SHALL have parameter WREG, default 32, the weight register width in bits; it is a multiple of LANES.
REQ-003 SHALL have parameter DREG, default 128, the data register width in bits; it is a multiple of LANES.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port din, input, LANES bits: the parallel-serial beat data.
REQ-007 SHALL have port din_valid, input, 1 bit: when high, din is one beat.
REQ-008 SHALL have port sel, input, 2 bits: the beat target; 01 = weights, 10 = data, 00 or 11 = none.
REQ-009 SHALL have port clr_w, input, 1 bit: synchronous clear of the weight path.
REQ-010 SHALL have port clr_d, input, 1 bit: synchronous clear of the data path.
REQ-011 SHALL have port err_clr, input, 1 bit: clears err_abort.
REQ-012 SHALL have port weights, output, WREG bits: the committed weight word.
REQ-013 SHALL have port data, output, DREG bits: the committed data word.
REQ-014 SHALL have port w_done, output, 1 bit: a one-cycle pulse on a weight commit.
REQ-015 SHALL have port d_done, output, 1 bit: a one-cycle pulse on a data commit.
REQ-016 SHALL have port busy, output, 1 bit: high while either frame counter is nonzero.
REQ-017 SHALL have port err_abort, output, 1 bit: sticky partial-frame abort flag.

Function
REQ-018 Each target (W, D) SHALL hold:
- a shadow shift register;
- a committed output register;
- a beat counter, 0..WREG/LANES-1 or 0..DREG/LANES-1.
REQ-019 A beat (din_valid=1, sel=01 or 10) SHALL shift that target's shadow left by LANES, insert din at the LSBs and increment its counter. The first beat lands in the MSBs of the final word.
REQ-020 On the last beat of a frame, the same clock edge SHALL:
- commit the shadow (including the final din) to the output;
- wrap the counter to 0;
- register the done pulse high for exactly the next cycle.
REQ-021 The committed outputs SHALL change only on a commit, a clear or reset; partial frames are never visible on weights or data.
REQ-022 A beat with sel=00 or sel=11 SHALL be ignored, with no state change.
REQ-023 Back-to-back frames with no idle cycle SHALL be accepted; every frame commits, one beat per cycle.
REQ-024 The per-cycle state machine SHALL track the previous valid target in {NONE, W, D}, updated on every cycle with din_valid=1.
REQ-025 Abort: when din_valid=1 and sel differs from the previous target, and that target's counter is nonzero, then on that edge:
- the previous target's shadow and counter SHALL clear;
- err_abort SHALL set;
- its output SHALL be unchanged;
- the new beat SHALL be processed normally.
REQ-026 clr_w SHALL zero the weight shadow, counter and committed weights, and suppress w_done; it takes priority over a concurrent weight beat. clr_d SHALL act the same on the data path.
REQ-027 err_clr SHALL clear err_abort; if a new abort occurs in the same cycle, the set SHALL win.
REQ-028 busy SHALL be the registered OR of (W counter != 0) and (D counter != 0).
REQ-029 The W and D paths SHALL be independent; a clear on one SHALL not affect the other.

Reset
REQ-030 rst_n=0 SHALL immediately and asynchronously zero:
- both shadows, both counters and both outputs;
- w_done, d_done, busy and err_abort;
- the previous target, set to NONE.
REQ-031 Reset asserted mid-frame SHALL discard the frame; the first beat after release SHALL start a new frame at count 0.
REQ-032 Reset release SHALL take effect on the first clk rising edge with rst_n=1.

Verification (LANES=4, WREG=32, DREG=128)
REQ-033 Reset: pulse rst_n low asynchronously between edges -> all outputs read 0 before the next edge.
REQ-034 Weight frame: 8 beats, sel=01, din=1,2,..,8 -> weights=0x12345678; w_done high exactly one cycle after the 8th beat; busy low after the commit.
REQ-035 Abort: 3 beats to W (0xA,0xB,0xC), then 1 beat sel=10 -> err_abort=1; weights unchanged; the W counter is 0; the D counter is 1; err_clr -> err_abort=0.
REQ-036 Streaming: two back-to-back 32-beat D frames, all 0xF then all 0x3 -> data=all-F after the first frame, all-3 after the second; d_done pulses twice, 32 cycles apart.
REQ-037 Clear priority: clr_w asserted with the 8th W beat -> weights=0; no w_done pulse; the next 8 beats of 0x5 give weights=0x55555555.
REQ-038 Reset mid-frame: 4 W beats, rst_n pulse, then 8 beats 0x9 -> weights=0x99999999; err_abort=0.

Source files
------------

// File: rtl/multi_spi_loader.sv
// multi_spi_loader
//   Collects LANES-bit beats into two independent frame registers: a WREG-bit
//   weight word (sel=01) and a DREG-bit data word (sel=10). Each path shifts
//   beats into a shadow register, MSB-first. On the last beat of a frame it
//   copies the shadow to the committed output and pulses a done flag for one
//   cycle. If the beat stream switches target in the middle of a frame, the
//   unfinished frame is dropped and err_abort is flagged.
//
// Handshake: din_valid qualifies din/sel for one clk cycle. There is no
//   backpressure. Every qualified beat is consumed on the rising edge it is
//   presented at, so one beat per cycle is always accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   din[LANES]        beat data
//   din_valid         beat qualifier
//   sel[2]            01 = weights, 10 = data, 00/11 = ignored
//   clr_w, clr_d      synchronous clear of the weight / data path
//   err_clr           clears err_abort (a simultaneous abort wins)
//   weights[WREG]     committed weight word
//   data[DREG]        committed data word
//   w_done, d_done    one-cycle commit pulses
//   busy              registered: a frame is partially loaded on either path
//   err_abort         sticky partial-frame abort flag
module multi_spi_loader #(
  parameter int LANES = 4,
  parameter int WREG  = 32,
  parameter int DREG  = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] din,
  input  logic             din_valid,
  input  logic [1:0]       sel,
  input  logic             clr_w,
  input  logic             clr_d,
  input  logic             err_clr,
  output logic [WREG-1:0]  weights,
  output logic [DREG-1:0]  data,
  output logic             w_done,
  output logic             d_done,
  output logic             busy,
  output logic             err_abort
);

  localparam int WBEATS = WREG / LANES;
  localparam int DBEATS = DREG / LANES;
  localparam int WCW    = (WBEATS > 1) ? $clog2(WBEATS) : 1;
  localparam int DCW    = (DBEATS > 1) ? $clog2(DBEATS) : 1;

  // Previous valid target; this is the whole per-cycle state machine.
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_W    = 2'd1,
    TGT_D    = 2'd2
  } tgt_e;

  tgt_e state_q, state_d;

  logic beat_w, beat_d;
  logic abort_w, abort_d;

  logic [WREG-1:0] w_sh_q, w_sh_d, weights_q, weights_d, w_shift;
  logic [DREG-1:0] d_sh_q, d_sh_d, data_q, data_d, d_shift;
  logic [WCW-1:0]  w_cnt_q, w_cnt_d;
  logic [DCW-1:0]  d_cnt_q, d_cnt_d;
  logic            w_done_q, w_done_d, d_done_q, d_done_d;
  logic            busy_q, err_q, err_d;

  // sel=00/11 beats are not beats at all: they touch no state, including
  // the previous-target tracker.
  assign beat_w = din_valid && (sel == 2'b01);
  assign beat_d = din_valid && (sel == 2'b10);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TGT_NONE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (beat_w)      state_d = TGT_W;
    else if (beat_d) state_d = TGT_D;
  end

  // ---------------- FSM: outputs (abort decode) ----------------
  // An abort fires only when the previous target holds a partial frame. A
  // target that has just committed has its counter at 0, so switching after
  // a complete frame is legal.
  always_comb begin
    abort_w = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      TGT_W:   abort_w = beat_d && (w_cnt_q != '0);
      TGT_D:   abort_d = beat_w && (d_cnt_q != '0);
      default: ;
    endcase
  end

  // ---------------- weight path ----------------
  assign w_shift = (w_sh_q << LANES) | WREG'(din);

  always_comb begin
    w_sh_d    = w_sh_q;
    w_cnt_d   = w_cnt_q;
    weights_d = weights_q;
    w_done_d  = 1'b0;
    if (clr_w) begin
      w_sh_d    = '0;
      w_cnt_d   = '0;
      weights_d = '0;
    end else if (beat_w) begin
      w_sh_d = w_shift;
      if (w_cnt_q == WCW'(WBEATS - 1)) begin
        weights_d = w_shift;
        w_cnt_d   = '0;
        w_done_d  = 1'b1;
      end else begin
        w_cnt_d = w_cnt_q + WCW'(1);
      end
    end else if (abort_w) begin
      w_sh_d  = '0;
      w_cnt_d = '0;
    end
  end

  // ---------------- data path ----------------
  assign d_shift = (d_sh_q << LANES) | DREG'(din);

  always_comb begin
    d_sh_d   = d_sh_q;
    d_cnt_d  = d_cnt_q;
    data_d   = data_q;
    d_done_d = 1'b0;
    if (clr_d) begin
      d_sh_d  = '0;
      d_cnt_d = '0;
      data_d  = '0;
    end else if (beat_d) begin
      d_sh_d = d_shift;
      if (d_cnt_q == DCW'(DBEATS - 1)) begin
        data_d   = d_shift;
        d_cnt_d  = '0;
        d_done_d = 1'b1;
      end else begin
        d_cnt_d = d_cnt_q + DCW'(1);
      end
    end else if (abort_d) begin
      d_sh_d  = '0;
      d_cnt_d = '0;
    end
  end

  // A new abort takes priority over err_clr in the same cycle.
  always_comb begin
    err_d = err_q;
    if (abort_w || abort_d) err_d = 1'b1;
    else if (err_clr)       err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_sh_q    <= '0;
      w_cnt_q   <= '0;
      weights_q <= '0;
      w_done_q  <= 1'b0;
      d_sh_q    <= '0;
      d_cnt_q   <= '0;
      data_q    <= '0;
      d_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      w_sh_q    <= w_sh_d;
      w_cnt_q   <= w_cnt_d;
      weights_q <= weights_d;
      w_done_q  <= w_done_d;
      d_sh_q    <= d_sh_d;
      d_cnt_q   <= d_cnt_d;
      data_q    <= data_d;
      d_done_q  <= d_done_d;
      // Registered from the next counter values, so busy tracks the counters
      // in the same cycle they change.
      busy_q    <= (w_cnt_d != '0) || (d_cnt_d != '0);
      err_q     <= err_d;
    end
  end

  assign weights   = weights_q;
  assign data      = data_q;
  assign w_done    = w_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;
  assign err_abort = err_q;

endmodule
